// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage controller for the multicycle divider.
// It launches a DIV/DIVU, stalls the pipeline while the divider runs,
// annuls the divider on a flush, and presents {remainder, quotient}
// as a one-cycle HI/LO write.
module div_ctrl #(
  parameter int unsigned ABORT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req,
  input  logic        ex_signed,
  input  logic [31:0] ex_op1,
  input  logic [31:0] ex_op2,
  input  logic        flush,
  output logic        stall_req,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_op1,
  output logic [31:0] div_op2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        result_valid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero
);

  localparam int unsigned CW = $clog2(ABORT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ABORT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] abort_cnt, abort_cnt_nx;
  logic          start_nx;
  logic          latch_en;

  // Next-state, stall, annul and result-pulse decode.
  always_comb begin
    state_nx     = state;
    abort_cnt_nx = abort_cnt;
    start_nx     = div_start;
    latch_en     = 1'b0;
    stall_req    = 1'b0;
    div_annul    = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        stall_req = ex_div_req & ~flush;
        if (ex_div_req && !flush) begin
          latch_en = 1'b1;
          start_nx = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        // A flush cycle never stalls, same as a flushed launch in IDLE.
        stall_req = ~div_ready & ~flush;
        if (flush) begin
          div_annul    = 1'b1;
          start_nx     = 1'b0;
          abort_cnt_nx = '0;
          state_nx     = ABORT;
        end else if (div_ready) begin
          result_valid = 1'b1;
          start_nx     = 1'b0;
          state_nx     = DONE;
        end
      end
      DONE: begin
        stall_req = ex_div_req;
        state_nx  = IDLE;
      end
      ABORT: begin
        div_annul = 1'b1;
        if (abort_cnt == CW'(ABORT_CYCLES - 1)) begin
          abort_cnt_nx = '0;
          state_nx     = IDLE;
        end else begin
          abort_cnt_nx = abort_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, abort counter and divider start register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      abort_cnt <= '0;
      div_start <= 1'b0;
    end else begin
      state     <= state_nx;
      abort_cnt <= abort_cnt_nx;
      div_start <= start_nx;
    end
  end

  // Operand latch: held from launch until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_signed <= 1'b0;
      div_op1    <= '0;
      div_op2    <= '0;
    end else if (latch_en) begin
      div_signed <= ex_signed;
      div_op1    <= ex_op1;
      div_op2    <= ex_op2;
    end
  end

  // HI/LO data is forced to zero outside the result pulse.
  always_comb begin
    hi_o        = result_valid ? div_result[63:32] : '0;
    lo_o        = result_valid ? div_result[31:0]  : '0;
    div_by_zero = result_valid & (div_op2 == '0);
  end

endmodule
